// File: rtl/ysyx_23060171_exu_stage_pkg.sv
// Shared encodings and defaults for the NPC execute stage.
package ysyx_23060171_exu_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RW_DEF   = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_OR  = 3'b011
    } alu_ctl_e;

    // Conditional branches are every encoding except "none" and "jump".
    function automatic logic is_cond_branch(input logic [2:0] br);
        return (br != BR_NONE) && (br != BR_JUMP);
    endfunction

endpackage

// File: rtl/ysyx_23060171_exu_stage_alu.sv
// 32-bit ALU: add/sub/xor/or with carry, overflow, zero and negative flags.
// For subtraction cf=1 means no borrow (a >= b unsigned).
module ysyx_23060171_alu
    import ysyx_23060171_exu_stage_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_ctl,
    output logic [31:0] o_result,
    output logic        o_cf,
    output logic        o_of,
    output logic        o_zf,
    output logic        o_nf
);

    logic        w_is_sub;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum;

    assign w_is_sub = (i_ctl == ALU_SUB);
    assign w_b_eff  = w_is_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, w_is_sub};

    // Result select; undefined controls fall to zero.
    always_comb begin
        o_result = '0;
        case (i_ctl)
            ALU_ADD, ALU_SUB: o_result = w_sum[31:0];
            ALU_XOR:          o_result = i_a ^ i_b;
            ALU_OR:           o_result = i_a | i_b;
            default:          o_result = '0;
        endcase
    end

    assign o_cf = w_sum[32];
    assign o_of = (i_a[31] == w_b_eff[31]) && (w_sum[31] != i_a[31]);
    assign o_zf = (o_result == 32'd0);
    assign o_nf = o_result[31];

endmodule

// File: rtl/ysyx_23060171_exu_stage.sv
// Execute stage: operand select, ALU, branch/jump resolution and a
// one-entry output buffer with valid/ready on both sides plus flush.
// The ALU is fixed at 32 bits, so XLEN must stay 32.
module ysyx_23060171_exu_stage
    import ysyx_23060171_exu_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RW   = RW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_asel,
    input  logic            in_bsel,
    input  logic [2:0]      in_aluctl,
    input  logic [2:0]      in_br,
    input  logic            in_jr,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RW-1:0]   out_rd,
    output logic            out_wen,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target
);

    logic            w_is_cond;
    logic            w_is_jump;
    logic [31:0]     w_alu_a;
    logic [31:0]     w_alu_b;
    logic [2:0]      w_alu_ctl;
    logic [31:0]     w_alu_result;
    logic            w_cf;
    logic            w_of;
    logic            w_zf;
    logic            w_nf;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_rs1_imm;
    logic [XLEN-1:0] w_pc_4;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_result;
    logic            w_wen;
    logic            w_in_fire;
    logic            w_out_fire;

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_target;
    logic [RW-1:0]   r_rd;
    logic            r_wen;
    logic            r_taken;

    assign w_is_cond = is_cond_branch(in_br);
    assign w_is_jump = (in_br == BR_JUMP);

    // Conditional branches always compare rs1 against rs2 via subtraction.
    assign w_alu_a   = w_is_cond ? in_rs1 : (in_asel ? in_pc : in_rs1);
    assign w_alu_b   = w_is_cond ? in_rs2 : (in_bsel ? in_imm : in_rs2);
    assign w_alu_ctl = w_is_cond ? ALU_SUB : in_aluctl;

    ysyx_23060171_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_ctl    (w_alu_ctl),
        .o_result (w_alu_result),
        .o_cf     (w_cf),
        .o_of     (w_of),
        .o_zf     (w_zf),
        .o_nf     (w_nf)
    );

    assign w_eq  = w_zf;
    assign w_lt  = w_nf ^ w_of;
    assign w_ltu = ~w_cf;

    // Branch decision from the ALU flags; jumps are always taken.
    always_comb begin
        w_taken = 1'b0;
        case (in_br)
            BR_BEQ:  w_taken = w_eq;
            BR_BNE:  w_taken = ~w_eq;
            BR_BLT:  w_taken = w_lt;
            BR_BGE:  w_taken = ~w_lt;
            BR_BLTU: w_taken = w_ltu;
            BR_BGEU: w_taken = ~w_ltu;
            BR_JUMP: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc_imm  = in_pc + in_imm;
    assign w_rs1_imm = in_rs1 + in_imm;
    assign w_pc_4    = in_pc + 32'd4;
    assign w_target  = (w_is_jump && in_jr) ? (w_rs1_imm & ~32'd1) : w_pc_imm;
    assign w_result  = w_is_jump ? w_pc_4 : w_alu_result;
    assign w_wen     = w_is_cond ? 1'b0 : in_wen;

    assign in_ready   = ~r_valid | out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_valid & out_ready;

    // Output buffer: flush beats a new accept, a new accept beats a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_target <= '0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
            r_taken  <= 1'b0;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (w_in_fire) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_target <= w_target;
            r_rd     <= in_rd;
            r_wen    <= w_wen;
            r_taken  <= w_taken;
        end else if (w_out_fire) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_result   = r_result;
    assign out_target   = r_target;
    assign out_rd       = r_rd;
    assign out_wen      = r_valid & r_wen;
    assign out_redirect = r_valid & r_taken;

endmodule

// File: tb/tb_ysyx_23060171_exu_stage.sv
module tb_ysyx_23060171_exu_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        asel;
        logic        bsel;
        logic [2:0]  aluctl;
        logic [2:0]  br;
        logic        jr;
        logic [4:0]  rd;
        logic        wen;
    } op_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        wen;
        logic        redirect;
        logic        chk_result;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic        in_asel = 1'b0, in_bsel = 1'b0;
    logic [2:0]  in_aluctl = '0, in_br = '0;
    logic        in_jr = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_redirect;
    logic [31:0] out_target;

    int   n_checks = 0;
    int   n_err = 0;
    int   n_pops = 0;
    exp_t sb[$];
    logic last_fire;
    logic mon_prev_stall = 1'b0;
    logic mon_prev_flush = 1'b0;
    logic [31:0] snap_result, snap_target;
    logic [4:0]  snap_rd;
    logic        snap_valid, snap_wen, snap_redirect;

    ysyx_23060171_exu_stage #(.XLEN(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_asel(in_asel), .in_bsel(in_bsel), .in_aluctl(in_aluctl),
        .in_br(in_br), .in_jr(in_jr), .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
        .out_redirect(out_redirect), .out_target(out_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model straight from the ISA-level rules.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        logic [31:0] a, b;
        e = '0;
        e.rd = op.rd;
        e.chk_result = 1'b1;
        e.target = op.pc + op.imm;
        if (op.br == 3'd0) begin
            a = op.asel ? op.pc : op.rs1;
            b = op.bsel ? op.imm : op.rs2;
            case (op.aluctl)
                3'd0: e.result = a + b;
                3'd1: e.result = a - b;
                3'd2: e.result = a ^ b;
                3'd3: e.result = a | b;
                default: e.chk_result = 1'b0;
            endcase
            e.wen = op.wen;
            e.redirect = 1'b0;
        end else if (op.br == 3'd7) begin
            e.result = op.pc + 32'd4;
            e.wen = op.wen;
            e.redirect = 1'b1;
            if (op.jr) e.target = (op.rs1 + op.imm) & 32'hFFFF_FFFE;
        end else begin
            e.chk_result = 1'b0;
            e.wen = 1'b0;
            case (op.br)
                3'd1: e.redirect = (op.rs1 == op.rs2);
                3'd2: e.redirect = (op.rs1 != op.rs2);
                3'd3: e.redirect = ($signed(op.rs1) < $signed(op.rs2));
                3'd4: e.redirect = !($signed(op.rs1) < $signed(op.rs2));
                3'd5: e.redirect = (op.rs1 < op.rs2);
                default: e.redirect = !(op.rs1 < op.rs2);
            endcase
        end
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op.pc     = $urandom & 32'hFFFF_FFFC;
        op.rs1    = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
        op.rs2    = $urandom_range(0, 3) == 0 ? op.rs1 : $urandom;
        if ($urandom_range(0, 3) == 0) op.rs2 = op.rs1 ^ 32'h8000_0000;
        op.imm    = $urandom;
        op.asel   = 1'($urandom_range(0, 1));
        op.bsel   = 1'($urandom_range(0, 1));
        op.aluctl = $urandom_range(0, 5) == 0 ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        op.br     = 3'($urandom_range(0, 7));
        op.jr     = 1'($urandom_range(0, 1));
        op.rd     = 5'($urandom_range(0, 31));
        op.wen    = 1'($urandom_range(0, 1));
        return op;
    endfunction

    function automatic op_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] ctl,
                               input logic [2:0] br, input logic jr, input logic [4:0] rd);
        op_t op;
        op = '0;
        op.pc = pc; op.rs1 = rs1; op.rs2 = rs2; op.imm = imm;
        op.aluctl = ctl; op.br = br; op.jr = jr; op.rd = rd; op.wen = 1'b1;
        return op;
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input op_t op, input logic v, input logic ordy, input logic fl);
        in_pc = op.pc; in_rs1 = op.rs1; in_rs2 = op.rs2; in_imm = op.imm;
        in_asel = op.asel; in_bsel = op.bsel; in_aluctl = op.aluctl;
        in_br = op.br; in_jr = op.jr; in_rd = op.rd; in_wen = op.wen;
        in_valid = v;
        flush = fl;
        out_ready = fl ? 1'b0 : ordy;
        @(negedge clk);
        last_fire = v && in_ready;
        if (fl) sb.delete();
        else if (last_fire) sb.push_back(model(op));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the WBU side takes an op.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!out_valid) check("wen_gated", {31'd0, out_wen}, 32'd0);
                check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
                if (mon_prev_stall && !mon_prev_flush) begin
                    check("stall_valid", {31'd0, out_valid}, {31'd0, snap_valid});
                    check("stall_result", out_result, snap_result);
                    check("stall_target", out_target, snap_target);
                    check("stall_rd", {27'd0, out_rd}, {27'd0, snap_rd});
                    check("stall_wen", {31'd0, out_wen}, {31'd0, snap_wen});
                    check("stall_redirect", {31'd0, out_redirect}, {31'd0, snap_redirect});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        n_pops++;
                        if (e.chk_result) check("result", out_result, e.result);
                        check("rd", {27'd0, out_rd}, {27'd0, e.rd});
                        check("wen", {31'd0, out_wen}, {31'd0, e.wen});
                        check("redirect", {31'd0, out_redirect}, {31'd0, e.redirect});
                        if (e.redirect) check("target", out_target, e.target);
                    end
                end
                mon_prev_stall = out_valid && !out_ready;
                mon_prev_flush = flush;
                snap_valid = out_valid; snap_result = out_result; snap_target = out_target;
                snap_rd = out_rd; snap_wen = out_wen; snap_redirect = out_redirect;
            end else begin
                mon_prev_stall = 1'b0;
            end
        end
    end

    initial begin
        op_t op;
        op_t idle;
        idle = '0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_wen", {31'd0, out_wen}, 32'd0);
        check("rst_redirect", {31'd0, out_redirect}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_target", out_target, 32'd0);
        check("rst_rd", {27'd0, out_rd}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add
        drive(mk(32'h0, 32'd5, 32'd7, 32'd0, 3'd0, 3'd0, 1'b0, 5'd3), 1'b1, 1'b1, 1'b0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", out_result, 32'd12);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_wen", {31'd0, out_wen}, 32'd1);
        check("add_redirect", {31'd0, out_redirect}, 32'd0);

        // blt signed taken
        drive(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'd0, 3'd3, 1'b0, 5'd4), 1'b1, 1'b1, 1'b0);
        check("blt_redirect", {31'd0, out_redirect}, 32'd1);
        check("blt_target", out_target, 32'h8000_0010);
        check("blt_wen", {31'd0, out_wen}, 32'd0);

        // bltu with the same operands not taken
        drive(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'd0, 3'd5, 1'b0, 5'd4), 1'b1, 1'b1, 1'b0);
        check("bltu_redirect", {31'd0, out_redirect}, 32'd0);
        check("bltu_valid", {31'd0, out_valid}, 32'd1);

        // jalr
        drive(mk(32'h8000_0020, 32'h8000_0103, 32'd0, 32'd4, 3'd0, 3'd7, 1'b1, 5'd1), 1'b1, 1'b1, 1'b0);
        check("jalr_target", out_target, 32'h8000_0106);
        check("jalr_result", out_result, 32'h8000_0024);
        check("jalr_redirect", {31'd0, out_redirect}, 32'd1);

        // backpressure: three stalled cycles, then accept with no bubble
        op = mk(32'h100, 32'd20, 32'd3, 32'd0, 3'd1, 3'd0, 1'b0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            drive(op, 1'b1, 1'b0, 1'b0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_no_fire", {31'd0, last_fire}, 32'd0);
            check("bp_hold_result", out_result, 32'h8000_0024);
        end
        drive(op, 1'b1, 1'b1, 1'b0);
        check("bp_release_fire", {31'd0, last_fire}, 32'd1);
        check("bp_new_result", out_result, 32'd17);
        check("bp_new_valid", {31'd0, out_valid}, 32'd1);

        // flush on the accept edge
        drive(idle, 1'b0, 1'b1, 1'b0);
        check("pre_flush_empty", {31'd0, out_valid}, 32'd0);
        drive(mk(32'h0, 32'd1, 32'd1, 32'd0, 3'd0, 3'd0, 1'b0, 5'd7), 1'b1, 1'b1, 1'b1);
        check("flush_fire_dropped", {31'd0, out_valid}, 32'd0);
        drive(idle, 1'b0, 1'b1, 1'b0);
        check("flush_never_shown", {31'd0, out_valid}, 32'd0);

        // async reset while an op is buffered
        drive(mk(32'h0, 32'd2, 32'd2, 32'd0, 3'd0, 3'd0, 1'b0, 5'd5), 1'b1, 1'b1, 1'b0);
        check("prerst_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        mon_prev_stall = 1'b0;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", out_result, 32'd0);
        check("arst_rd", {27'd0, out_rd}, 32'd0);
        #1 rst_n = 1'b1;
        #0;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(rand_op(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 4; i++) drive(idle, 1'b0, 1'b1, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        n_checks++;
        if (n_pops < 500) begin
            n_err++;
            $display("FAIL pops: got %0d required at least 500", n_pops);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
